// File: rtl/seg_display_scanner.sv
// Multiplexed 4-digit 7-segment scanner with frame-aligned input shadowing,
// per-digit blink cursor and decimal-point control. All outputs registered.
module seg_display_scanner #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] num,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [7:0]  seg,
  output logic [3:0]  anode,
  output logic [3:0]  sel,
  output logic        frame_done
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  digit_e               idx_q, idx_d;
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;
  logic [15:0]          num_sh_q, num_sh_d;
  logic [3:0]           blink_sh_q, blink_sh_d;
  logic [3:0]           dp_sh_q, dp_sh_d;
  logic [7:0]           seg_q, seg_d;
  logic [3:0]           anode_q, anode_d;
  logic [3:0]           sel_q, sel_d;
  logic                 frame_done_q, frame_done_d;

  logic                 scan_wrap;
  logic                 frame_wrap;
  logic                 blink_wrap;
  logic [3:0]           nibble;
  logic [3:0]           onehot;
  logic                 digit_on;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] p;
    p = 7'b1111111;
    unique case (d)
      4'd0: p = 7'b1000000;
      4'd1: p = 7'b1111001;
      4'd2: p = 7'b0100100;
      4'd3: p = 7'b0110000;
      4'd4: p = 7'b0011001;
      4'd5: p = 7'b0010010;
      4'd6: p = 7'b0000010;
      4'd7: p = 7'b1111000;
      4'd8: p = 7'b0000000;
      4'd9: p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Scan and blink timebases plus frame-boundary shadow capture
  always_comb begin
    scan_wrap     = (scan_cnt_q == SCAN_MAX);
    scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d         = idx_q;
    if (scan_wrap) begin
      unique case (idx_q)
        DIG0: idx_d = DIG1;
        DIG1: idx_d = DIG2;
        DIG2: idx_d = DIG3;
        DIG3: idx_d = DIG0;
        default: idx_d = DIG0;
      endcase
    end
    frame_wrap    = scan_wrap && (idx_q == DIG3);

    blink_wrap    = (blink_cnt_q == BLINK_MAX);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;

    num_sh_d      = frame_wrap ? num        : num_sh_q;
    blink_sh_d    = frame_wrap ? blink_mask : blink_sh_q;
    dp_sh_d       = frame_wrap ? dp_mask    : dp_sh_q;
  end

  // Output decode works on the current digit, so outputs trail idx by one cycle
  always_comb begin
    nibble = 4'h0;
    unique case (idx_q)
      DIG0: nibble = num_sh_q[3:0];
      DIG1: nibble = num_sh_q[7:4];
      DIG2: nibble = num_sh_q[11:8];
      DIG3: nibble = num_sh_q[15:12];
      default: nibble = 4'h0;
    endcase
    onehot       = 4'b0001 << idx_q;
    digit_on     = enable && !(|(blink_sh_q & onehot) && !blink_phase_q);

    seg_d        = 8'hFF;
    if (digit_on) begin
      seg_d[6:0] = bcd_to_seg(nibble);
      seg_d[7]   = ~|(dp_sh_q & onehot);
    end
    anode_d      = enable ? ~onehot : 4'b1111;
    sel_d        = onehot;
    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      idx_q         <= DIG0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      num_sh_q      <= '0;
      blink_sh_q    <= '0;
      dp_sh_q       <= '0;
      seg_q         <= '1;
      anode_q       <= '1;
      sel_q         <= 4'b0001;
      frame_done_q  <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      num_sh_q      <= num_sh_d;
      blink_sh_q    <= blink_sh_d;
      dp_sh_q       <= dp_sh_d;
      seg_q         <= seg_d;
      anode_q       <= anode_d;
      sel_q         <= sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign anode      = anode_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench: directed scenarios plus random stimulus, compared every
// cycle against an arithmetic model derived from the cycle count since reset.
module tb_seg_display_scanner;

  localparam int SD = 4;
  localparam int BD = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic [15:0] num_i = 16'h0000;
  logic [3:0]  blink_i = 4'h0;
  logic [3:0]  dp_i = 4'h0;
  logic [7:0]  seg;
  logic [3:0]  anode;
  logic [3:0]  sel;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: edges since reset release plus frame shadows
  int          n_edges;
  logic [15:0] m_num;
  logic [3:0]  m_blink;
  logic [3:0]  m_dp;
  logic [7:0]  e_seg;
  logic [3:0]  e_anode;
  logic [3:0]  e_sel;
  logic        e_fd;

  localparam logic [6:0] DIGIT_SEGS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  seg_display_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .reset      (rst),
    .enable     (en),
    .num        (num_i),
    .blink_mask (blink_i),
    .dp_mask    (dp_i),
    .seg        (seg),
    .anode      (anode),
    .sel        (sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int d;
    int k;
    bit visible;
    logic [3:0] nib;
    d       = (n_edges / SD) % 4;
    visible = en && !(m_blink[d] && (((n_edges / BD) % 2) == 1));
    nib     = 4'((m_num >> (4 * d)) & 16'hF);
    e_sel   = 4'(1 << d);
    e_anode = en ? ~e_sel : 4'hF;
    e_seg   = 8'hFF;
    if (visible) begin
      k = int'(nib);
      e_seg[6:0] = (k < 10) ? DIGIT_SEGS[k] : 7'h7F;
      e_seg[7]   = ~m_dp[d];
    end
    e_fd = ((n_edges % (4 * SD)) == (4 * SD - 1));
    if (e_fd) begin
      m_num   = num_i;
      m_blink = blink_i;
      m_dp    = dp_i;
    end
    n_edges++;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_seg"},   32'(seg),        32'(e_seg));
    check({pfx, "_anode"}, 32'(anode),      32'(e_anode));
    check({pfx, "_sel"},   32'(sel),        32'(e_sel));
    check({pfx, "_fd"},    32'(frame_done), 32'(e_fd));
  endtask

  task automatic step(input string pfx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(pfx);
  endtask

  task automatic run(input string pfx, input int cycles);
    for (int i = 0; i < cycles; i++) step(pfx);
  endtask

  // reset is raised and dropped between clock edges
  task automatic do_reset(input string pfx);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_edges = 0;
    m_num = '0; m_blink = '0; m_dp = '0;
    e_seg = 8'hFF; e_anode = 4'hF; e_sel = 4'b0001; e_fd = 1'b0;
    check_outputs({pfx, "_async"});
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_outputs({pfx, "_rel"});
  endtask

  initial begin
    int guard;
    num_i = 16'h1234; en = 1'b1; blink_i = 4'h0; dp_i = 4'h0;
    do_reset("rst0");

    run("t1", 4 * SD * 2);

    // change num while digit1 is being scanned
    for (int i = 0; i < SD + 2; i++) step("t2a");
    num_i = 16'h5959;
    run("t2", 4 * SD * 3);

    blink_i = 4'b0001;
    run("t3", 4 * BD + 8);
    blink_i = 4'b0000;

    dp_i = 4'b0100;
    num_i = 16'hC959;
    run("t4", 4 * SD * 3);

    en = 1'b0;
    run("t5off", 40);
    en = 1'b1;
    run("t5on", 4 * SD * 2);

    guard = 0;
    while (sel !== 4'b0100 && guard < 64) begin
      step("t6w");
      guard++;
    end
    check("t6_reach_digit2", 32'(sel), 32'h4);
    do_reset("t6");
    run("t6", 4 * SD * 3);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7, 0) == 0) num_i = 16'($urandom);
      if ($urandom_range(7, 0) == 0) blink_i = 4'($urandom);
      if ($urandom_range(7, 0) == 0) dp_i = 4'($urandom);
      if ($urandom_range(15, 0) == 0) en = ~en;
      if ($urandom_range(299, 0) == 0) do_reset("rnd");
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
